// File: rtl/cp_inserter_pkg.sv
// Shared PHY definitions for the cyclic-prefix inserter and the FFT demodulator:
// metadata field widths, symbol/CP length helpers, default-numerology constants
// and the read-side state encoding.
package cp_inserter_pkg;

  localparam int unsigned SFN_W      = 10;
  localparam int unsigned SUBFRAME_W = 5;
  localparam int unsigned SYMBOL_W   = 4;
  localparam int unsigned META_W     = SFN_W + SUBFRAME_W + SYMBOL_W;

  // Symbol length and CP lengths (CP scales with FFT size, 20/18 per 256)
  function automatic int unsigned fft_len(input int unsigned nfft);
    return 32'd1 << nfft;
  endfunction

  function automatic int unsigned cp1_len(input int unsigned nfft);
    return (32'd20 * fft_len(nfft)) / 32'd256;
  endfunction

  function automatic int unsigned cp2_len(input int unsigned nfft);
    return (32'd18 * fft_len(nfft)) / 32'd256;
  endfunction

  function automatic int unsigned cp_w(input int unsigned nfft);
    return $clog2(cp1_len(nfft));
  endfunction

  // Default numerology (NFFT = 8)
  localparam int unsigned NFFT_DEFAULT = 8;
  localparam int unsigned FFT_LEN      = fft_len(NFFT_DEFAULT);
  localparam int unsigned CP1          = cp1_len(NFFT_DEFAULT);
  localparam int unsigned CP2          = cp2_len(NFFT_DEFAULT);
  localparam int unsigned CPW          = cp_w(NFFT_DEFAULT);

  typedef struct packed {
    logic [SFN_W-1:0]      sfn;
    logic [SUBFRAME_W-1:0] subframe;
    logic [SYMBOL_W-1:0]   symbol;
  } meta_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: clk_i clock; we/waddr/wdata write port; re/raddr read request,
// rdata registered read data (valid the cycle after re).
module dual_port_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 9
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage array carries no reset; validity is tracked by the caller
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter. Buffers one IFFT symbol per ping-pong bank and replays
// its tail (CP) followed by the whole symbol on an AXI-Stream output.
// Ports: clk_i/reset_ni clock and async active-low reset; s_axis_in_* sample
// input with {sfn,subframe,symbol} tuser; m_axis_out_* output with
// {meta,cp_len} tuser and tlast on the final body sample; len_err_o one-cycle
// pulse on an input symbol length violation.
module cp_inserter
  import cp_inserter_pkg::*;
#(
  parameter int unsigned IN_DW       = 32,
  parameter int unsigned NFFT        = 8,
  parameter int unsigned LONG_CP_SYM = 7
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [IN_DW-1:0]             s_axis_in_tdata,
  input  logic [META_W-1:0]            s_axis_in_tuser,
  input  logic                         s_axis_in_tlast,
  input  logic                         s_axis_in_tvalid,
  output logic                         s_axis_in_tready,
  output logic [IN_DW-1:0]             m_axis_out_tdata,
  output logic [META_W+cp_w(NFFT)-1:0] m_axis_out_tuser,
  output logic                         m_axis_out_tlast,
  output logic                         m_axis_out_tvalid,
  input  logic                         m_axis_out_tready,
  output logic                         len_err_o
);

  localparam int unsigned SYM_LEN  = fft_len(NFFT);
  localparam int unsigned CP_LONG  = cp1_len(NFFT);
  localparam int unsigned CP_SHORT = cp2_len(NFFT);
  localparam int unsigned CP_W     = cp_w(NFFT);
  localparam int unsigned UW       = META_W + CP_W;
  localparam int unsigned AW       = NFFT + 1;
  localparam logic [NFFT-1:0] LAST_IDX = NFFT'(SYM_LEN - 1);

  // Write side
  logic [1:0]             full_q;
  logic                   wr_bank_q;
  logic [NFFT-1:0]        wr_cnt_q;
  logic [1:0][META_W-1:0] meta_q;
  logic [1:0][CP_W-1:0]   cplen_q;
  logic                   len_err_q;
  logic                   wr_acc_c;
  logic                   is_long_c;
  meta_t                  in_meta_c;

  // Read side
  rd_state_e       state_q, state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [NFFT-1:0] rd_addr_q, rd_addr_d;
  logic [NFFT-1:0] rd_idx_c, cp_start_c, cp_start_nxt_c;
  logic            rd_en_c, rd_last_c, rd_free_c, space_c, pop_c;
  logic            rd_vld_q, rd_last_q;
  logic [UW-1:0]   rd_user_q;
  logic [IN_DW-1:0] ram_rdata;

  // Two-entry output skid; entry 0 drives the output
  logic             v0_q, v1_q, l0_q, l1_q;
  logic [IN_DW-1:0] d0_q, d1_q;
  logic [UW-1:0]    u0_q, u1_q;

  assign s_axis_in_tready = ~full_q[wr_bank_q];
  assign wr_acc_c         = s_axis_in_tvalid & s_axis_in_tready;
  assign in_meta_c        = meta_t'(s_axis_in_tuser);
  assign is_long_c        = (in_meta_c.symbol == '0) ||
                            (in_meta_c.symbol == SYMBOL_W'(LONG_CP_SYM));

  dual_port_ram #(
    .DW (IN_DW),
    .AW (AW)
  ) u_ram (
    .clk_i (clk_i),
    .we    (wr_acc_c),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata (s_axis_in_tdata),
    .re    (rd_en_c),
    .raddr ({rd_bank_q, rd_idx_c}),
    .rdata (ram_rdata)
  );

  // Input write counter, bank flags and per-bank metadata
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      meta_q    <= '0;
      cplen_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      // Read and write never target the same bank here, so both updates may coexist
      if (rd_free_c) full_q[rd_bank_q] <= 1'b0;
      if (wr_acc_c) begin
        if (wr_cnt_q == '0) begin
          meta_q[wr_bank_q]  <= s_axis_in_tuser;
          cplen_q[wr_bank_q] <= is_long_c ? CP_W'(CP_LONG) : CP_W'(CP_SHORT);
        end
        if (wr_cnt_q == LAST_IDX) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          wr_cnt_q          <= '0;
          len_err_q         <= ~s_axis_in_tlast;
        end else if (s_axis_in_tlast) begin
          // Short symbol: drop it and restart the bank
          wr_cnt_q  <= '0;
          len_err_q <= 1'b1;
        end else begin
          wr_cnt_q <= wr_cnt_q + NFFT'(1);
        end
      end
    end
  end

  // Issue a RAM read only if the skid can absorb it once it lands
  assign pop_c          = v0_q & m_axis_out_tready;
  assign space_c        = ~(v0_q & (v1_q | rd_vld_q)) | pop_c;
  assign cp_start_c     = NFFT'(SYM_LEN - 32'(cplen_q[rd_bank_q]));
  assign cp_start_nxt_c = NFFT'(SYM_LEN - 32'(cplen_q[~rd_bank_q]));

  // Read FSM; IDLE issues the first CP read itself to save a cycle of latency
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_idx_c  = rd_addr_q;
    rd_en_c   = 1'b0;
    rd_last_c = 1'b0;
    rd_free_c = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q] && space_c) begin
          rd_en_c  = 1'b1;
          rd_idx_c = cp_start_c;
          if (cp_start_c == LAST_IDX) begin
            state_d   = RD_BODY;
            rd_addr_d = '0;
          end else begin
            state_d   = RD_CP;
            rd_addr_d = cp_start_c + NFFT'(1);
          end
        end
      end
      RD_CP: begin
        if (space_c) begin
          rd_en_c = 1'b1;
          if (rd_addr_q == LAST_IDX) begin
            state_d   = RD_BODY;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + NFFT'(1);
          end
        end
      end
      RD_BODY: begin
        if (space_c) begin
          rd_en_c = 1'b1;
          if (rd_addr_q == LAST_IDX) begin
            rd_last_c = 1'b1;
            rd_free_c = 1'b1;
            rd_bank_d = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              state_d   = RD_CP;
              rd_addr_d = cp_start_nxt_c;
            end else begin
              state_d   = RD_IDLE;
              rd_addr_d = '0;
            end
          end else begin
            rd_addr_d = rd_addr_q + NFFT'(1);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // FSM state, read pipeline sideband and output skid
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= RD_IDLE;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_user_q <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      l0_q      <= 1'b0;
      l1_q      <= 1'b0;
      d0_q      <= '0;
      d1_q      <= '0;
      u0_q      <= '0;
      u1_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
      rd_vld_q  <= rd_en_c;
      if (rd_en_c) begin
        rd_last_q <= rd_last_c;
        rd_user_q <= {meta_q[rd_bank_q], cplen_q[rd_bank_q]};
      end
      if (pop_c) begin
        if (v1_q) begin
          d0_q <= d1_q;
          u0_q <= u1_q;
          l0_q <= l1_q;
          v1_q <= rd_vld_q;
          if (rd_vld_q) begin
            d1_q <= ram_rdata;
            u1_q <= rd_user_q;
            l1_q <= rd_last_q;
          end
        end else begin
          v0_q <= rd_vld_q;
          if (rd_vld_q) begin
            d0_q <= ram_rdata;
            u0_q <= rd_user_q;
            l0_q <= rd_last_q;
          end
        end
      end else if (rd_vld_q) begin
        if (!v0_q) begin
          v0_q <= 1'b1;
          d0_q <= ram_rdata;
          u0_q <= rd_user_q;
          l0_q <= rd_last_q;
        end else begin
          v1_q <= 1'b1;
          d1_q <= ram_rdata;
          u1_q <= rd_user_q;
          l1_q <= rd_last_q;
        end
      end
    end
  end

  assign m_axis_out_tvalid = v0_q;
  assign m_axis_out_tdata  = d0_q;
  assign m_axis_out_tuser  = u0_q;
  assign m_axis_out_tlast  = l0_q;
  assign len_err_o         = len_err_q;

endmodule

// File: tb/tb_cp_inserter.sv
// Directed bench for cp_inserter (NFFT=8, CP1=20, CP2=18).
module tb_cp_inserter;
  import cp_inserter_pkg::*;

  localparam int unsigned UW = META_W + CPW;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [31:0]   s_tdata;
  logic [18:0]   s_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic [31:0]   m_tdata;
  logic [UW-1:0] m_tuser;
  logic          m_tlast, m_tvalid, m_tready;
  logic          len_err;

  cp_inserter dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .s_axis_in_tdata   (s_tdata),
    .s_axis_in_tuser   (s_tuser),
    .s_axis_in_tlast   (s_tlast),
    .s_axis_in_tvalid  (s_tvalid),
    .s_axis_in_tready  (s_tready),
    .m_axis_out_tdata  (m_tdata),
    .m_axis_out_tuser  (m_tuser),
    .m_axis_out_tlast  (m_tlast),
    .m_axis_out_tvalid (m_tvalid),
    .m_axis_out_tready (m_tready),
    .len_err_o         (len_err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] d; logic [18:0] u; logic l; } in_t;
  typedef struct packed { logic [31:0] d; logic [UW-1:0] u; logic l; } out_t;

  in_t  in_q[$];
  out_t out_q[$];

  int n_vec = 0, n_mis = 0;
  int cyc = 0, n_acc = 0, n_lerr = 0;
  int last_acc = -1, first_v = -1, first_hs = -1, last_hs = -1;
  int mode = 1;  // 0: out tready low, 1: high, 2: random
  bit prev_stall = 1'b0;
  logic [31:0]   prev_d;
  logic [UW-1:0] prev_u;
  logic          prev_l;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, edge follows
  task automatic step();
    @(negedge clk_i);
    cyc++;
    if (in_q.size() > 0) begin
      s_tvalid = 1'b1;
      s_tdata  = in_q[0].d;
      s_tuser  = in_q[0].u;
      s_tlast  = in_q[0].l;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tuser  = '0;
      s_tlast  = 1'b0;
    end
    case (mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (prev_stall) begin
      chk("stall_tvalid", 64'(m_tvalid), 64'(1));
      chk("stall_tdata", 64'(m_tdata), 64'(prev_d));
      chk("stall_tuser", 64'(m_tuser), 64'(prev_u));
      chk("stall_tlast", 64'(m_tlast), 64'(prev_l));
    end
    prev_stall = m_tvalid && !m_tready;
    prev_d = m_tdata;
    prev_u = m_tuser;
    prev_l = m_tlast;
    if (len_err) n_lerr++;
    if (m_tvalid && first_v < 0) first_v = cyc;
    if (m_tvalid && m_tready) begin
      out_q.push_back('{d: m_tdata, u: m_tuser, l: m_tlast});
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    if (s_tvalid && s_tready) begin
      n_acc++;
      if (in_q[0].l) last_acc = cyc;
      void'(in_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  // Sample i of a symbol carries {tag, i}; tuser {sfn=5, subframe=3, symbol}
  task automatic send_sym(input int sym, input int tag, input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      in_q.push_back('{d: {16'(tag), 16'(i)}, u: {10'd5, 5'd3, 4'(sym)},
                       l: with_last && (i == n - 1)});
  endtask

  task automatic check_sym(input string tag, input int base, input int sym, input int dtag);
    int cp = (sym == 0 || sym == 7) ? 20 : 18;
    int len = cp + 256;
    logic [31:0]   ed;
    logic [UW-1:0] eu;
    if (out_q.size() < base + len) begin
      chk({tag, "_avail"}, 64'(out_q.size()), 64'(base + len));
      return;
    end
    eu = {10'd5, 5'd3, 4'(sym), 5'(cp)};
    for (int j = 0; j < len; j++) begin
      ed = {16'(dtag), 16'((j < cp) ? (256 - cp + j) : (j - cp))};
      chk($sformatf("%s_data[%0d]", tag, j), 64'(out_q[base + j].d), 64'(ed));
      chk($sformatf("%s_tuser[%0d]", tag, j), 64'(out_q[base + j].u), 64'(eu));
      chk($sformatf("%s_tlast[%0d]", tag, j), 64'(out_q[base + j].l), 64'(j == len - 1));
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_tlast), 64'(0));
    chk("rst_tdata", 64'(m_tdata), 64'(0));
    chk("rst_tuser", 64'(m_tuser), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
    reset_ni = 1'b1;
    #1;
    chk("rst_in_tready", 64'(s_tready), 64'(1));

    // Single short-CP symbol, ramp data, latency
    mode = 1;
    out_q.delete();
    first_v = -1;
    last_acc = -1;
    send_sym(1, 0, 256, 1'b1);
    run_until(274, 2000);
    idle(30);
    chk("t1_count", 64'(out_q.size()), 64'(274));
    check_sym("t1", 0, 1, 0);
    // Last input accepted at the edge ending cycle k; tvalid rises two edges later
    chk("t1_latency", 64'(first_v - last_acc), 64'(3));

    // Long-CP symbols 0 and 7 back to back
    out_q.delete();
    send_sym(0, 9, 256, 1'b1);
    send_sym(7, 10, 256, 1'b1);
    run_until(552, 3000);
    idle(30);
    chk("t2_count", 64'(out_q.size()), 64'(552));
    check_sym("t2_sym0", 0, 0, 9);
    check_sym("t2_sym7", 276, 7, 10);

    // Three symbols with output blocked, then released
    out_q.delete();
    mode = 0;
    n_acc = 0;
    send_sym(1, 1, 256, 1'b1);
    send_sym(2, 2, 256, 1'b1);
    send_sym(3, 3, 256, 1'b1);
    idle(700);
    chk("t3_accepted", 64'(n_acc), 64'(512));
    chk("t3_in_tready", 64'(s_tready), 64'(0));
    chk("t3_no_output", 64'(out_q.size()), 64'(0));
    chk("t3_tvalid_held", 64'(m_tvalid), 64'(1));
    mode = 1;
    first_hs = -1;
    run_until(822, 3000);
    idle(30);
    chk("t3_count", 64'(out_q.size()), 64'(822));
    chk("t3_no_bubble", 64'(last_hs - first_hs), 64'(821));
    check_sym("t3_s1", 0, 1, 1);
    check_sym("t3_s2", 274, 2, 2);
    check_sym("t3_s3", 548, 3, 3);

    // Random backpressure, same sequence as the first symbol
    out_q.delete();
    mode = 2;
    send_sym(1, 0, 256, 1'b1);
    run_until(274, 4000);
    idle(30);
    mode = 1;
    chk("t4_count", 64'(out_q.size()), 64'(274));
    check_sym("t4", 0, 1, 0);

    // Full-length symbol without tlast: flagged but still output
    out_q.delete();
    n_lerr = 0;
    send_sym(3, 6, 256, 1'b0);
    run_until(274, 2000);
    idle(30);
    chk("t5_len_err", 64'(n_lerr), 64'(1));
    chk("t5_count", 64'(out_q.size()), 64'(274));
    check_sym("t5", 0, 3, 6);

    // Early tlast at sample 100: flagged, discarded, next symbol clean
    out_q.delete();
    n_lerr = 0;
    send_sym(1, 7, 100, 1'b1);
    idle(150);
    chk("t6_len_err", 64'(n_lerr), 64'(1));
    chk("t6_no_output", 64'(out_q.size()), 64'(0));
    chk("t6_in_tready", 64'(s_tready), 64'(1));
    send_sym(7, 8, 256, 1'b1);
    run_until(276, 2000);
    idle(30);
    chk("t6_count", 64'(out_q.size()), 64'(276));
    check_sym("t6", 0, 7, 8);
    chk("t6_len_err_once", 64'(n_lerr), 64'(1));

    // Reset during output sample 50
    out_q.delete();
    send_sym(2, 4, 256, 1'b1);
    run_until(50, 2000);
    chk("t7_pre_tvalid", 64'(m_tvalid), 64'(1));
    reset_ni = 1'b0;
    #1;
    chk("t7_async_tvalid", 64'(m_tvalid), 64'(0));
    chk("t7_async_tlast", 64'(m_tlast), 64'(0));
    chk("t7_async_tdata", 64'(m_tdata), 64'(0));
    in_q.delete();
    out_q.delete();
    prev_stall = 1'b0;
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk_i);
    #2;
    reset_ni = 1'b1;
    #1;
    chk("t7_rel_in_tready", 64'(s_tready), 64'(1));
    chk("t7_rel_tvalid", 64'(m_tvalid), 64'(0));
    send_sym(2, 5, 256, 1'b1);
    run_until(274, 2000);
    idle(30);
    chk("t7_count", 64'(out_q.size()), 64'(274));
    check_sym("t7", 0, 2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/cp_inserter.md
CP_INSERTER -- requirements
Module: cp_inserter

Interface
REQ-001 SHALL have parameter IN_DW, default 32, sample width: {im[IN_DW/2-1:0], re[IN_DW/2-1:0]}.
REQ-002 SHALL have parameter NFFT, default 8, log2 of symbol length; FFT_LEN=2**NFFT, CP1=20*FFT_LEN/256, CP2=18*FFT_LEN/256.
REQ-003 SHALL have parameter LONG_CP_SYM, default 7, second symbol index per subframe that uses CP1; symbol 0 also uses CP1.
REQ-004 clk_i  in  1  single clock, all logic on rising edge.
REQ-005 reset_ni  in  1  reset; asynchronous, active-low.
REQ-006 s_axis_in_tdata  in  IN_DW  time-domain IFFT sample.
REQ-007 s_axis_in_tuser  in  META_W  {sfn[10], subframe[5], symbol[4]}; META_W=19; sampled on first sample of symbol.
REQ-008 s_axis_in_tlast / s_axis_in_tvalid  in  1 each  end of symbol / sample valid.
REQ-009 s_axis_in_tready  out  1  input accepted when tvalid&&tready.
REQ-010 m_axis_out_tdata  out  IN_DW  CP + symbol sample.
REQ-011 m_axis_out_tuser  out  META_W+CPW  {meta, cp_len}; CPW=$clog2(CP1); the input tuser format of the FFT demodulator.
REQ-012 m_axis_out_tlast / m_axis_out_tvalid  out  1 each  last body sample / output valid.
REQ-013 m_axis_out_tready  in  1  downstream ready.
REQ-014 len_err_o  out  1  one-cycle pulse on input length violation.

Function
REQ-015 Input buffer SHALL be ping-pong: 2 banks x FFT_LEN samples, each with full flag, meta register, cp_len register.
REQ-016 s_axis_in_tready SHALL equal !full[wr_bank], from registered flags only.
REQ-017 Accepted sample SHALL be written at wr_cnt in wr_bank; at wr_cnt==0, meta is latched and cp_len set to CP1 if symbol==0 or LONG_CP_SYM, else CP2.
REQ-018 At accepted wr_cnt==FFT_LEN-1: full[wr_bank] set, wr_bank toggled, wr_cnt cleared; missing tlast SHALL pulse len_err_o with the symbol still committed.
REQ-019 tlast accepted with wr_cnt<FFT_LEN-1 SHALL pulse len_err_o, discard the partial symbol (wr_cnt=0, bank not full) and produce no output for it.
REQ-020 Read FSM states SHALL be IDLE, CP, BODY. IDLE->CP when full[rd_bank]; rd_addr=FFT_LEN-cp_len.
REQ-021 CP: rd_addr increments per output handshake; after address FFT_LEN-1 -> BODY with rd_addr=0.
REQ-022 BODY: after address FFT_LEN-1 handshake, tlast=1 on that sample, full[rd_bank] cleared, rd_bank toggled; -> CP without bubble if other bank full, else IDLE.
REQ-023 Per symbol output SHALL be exactly cp_len+FFT_LEN samples: buf[FFT_LEN-cp_len..FFT_LEN-1] then buf[0..FFT_LEN-1].
REQ-024 m_axis_out_tuser SHALL be constant over all samples of a symbol; tlast only on final body sample.
REQ-025 Output SHALL be AXIS-compliant: tdata/tuser/tlast stable while tvalid&&!tready; synchronous RAM read handled by 2-entry skid stage; 1 sample/cycle at tready=1.
REQ-026 Latency SHALL be 2 cycles from acceptance of last input sample (FSM IDLE) to first output tvalid.
REQ-027 Bank freed by read in cycle N SHALL be writable from cycle N+1 (one stall cycle permitted); write and read to different banks in the same cycle SHALL not interact.
REQ-028 No arithmetic on samples; data passes bit-exact.

Reset
REQ-029 reset_ni low SHALL immediately clear full flags, banks pointers, counters, FSM->IDLE, skid stage; m_axis_out_tvalid/tlast/tdata/tuser=0, len_err_o=0, s_axis_in_tready=1 after release.
REQ-030 Reset mid-symbol SHALL discard all buffered and partially output data; no stale sample after release.

Structure
REQ-031 FFT_LEN, CP1, CP2, SFN/subframe/symbol widths, META_W, CPW SHALL live in the shared PHY package used by the demodulator.
REQ-032 Buffer SHALL be one sub-module dual_port_ram (1 write port, 1 sync read port, depth 2*FFT_LEN, address {bank, index}).

Verification (NFFT=8, CP1=20, CP2=18)
REQ-033 One symbol, symbol=1, data=ramp 0..255, out tready=1 -> 274 samples: 238..255, 0..255; tuser cp=18; tlast on sample 274 only.
REQ-034 symbol=0 and symbol=7 -> 276 samples each, first sample 236, cp=20.
REQ-035 Three back-to-back symbols, out tready=0 -> in tready low after 512 accepted; release -> 3x274 contiguous samples, no bubbles, order kept.
REQ-036 Random 50% out tready -> output sequence identical to REQ-033, stable under stall.
REQ-037 tlast at sample 100 -> len_err_o one pulse, no output; next full symbol output normally.
REQ-038 reset_ni low during output sample 50 -> tvalid=0 asynchronously; after release new symbol output from its CP start.
